// File: rtl/div_arbiter.sv
// div_arbiter
//   Round-robin arbiter and sequencer that shares one 8-bit non-restoring
//   divider among NREQ requesters. The winner's operands are latched at
//   grant time. The arbiter starts the divider, collects the quotient and
//   remainder from the divider's output bus, and returns them with a one-hot,
//   one-cycle done strobe.
//
//   Build option: DIVARB_REMAINDER_EN
//     defined   - quotient and remainder are both captured from the divider.
//     undefined - the remainder capture step is skipped, rem is tied to 0,
//                 and each operation takes one cycle less.
//
//   Ports
//     clk        in   system clock, rising edge
//     reset      in   asynchronous reset, active low
//     req        in   [NREQ]   request levels, held until own done pulse
//     m_in       in   [8*NREQ] divisors, requester i at [8*i+7:8*i]
//     q_in       in   [8*NREQ] dividends, same packing
//     done       out  [NREQ]   one-hot, one-cycle result strobe
//     quo        out  [8]      quotient, valid with done
//     rem        out  [8]      remainder, valid with done
//     dz         out           divide-by-zero flag, valid with done
//     arb_busy   out           high from grant through the done cycle
//     div_start  out           divider start
//     div_m      out  [8]      divider divisor operand
//     div_q      out  [8]      divider dividend operand
//     div_busy   in            divider busy
//     div_out    in   [8]      divider output bus (quotient, then remainder)
//     fsm_state  out  [3]      current sequencer state, for observation
//
//   Divider handshake: div_start is held high from START until div_busy is
//   seen high. The first cycle div_busy is seen low again, div_out carries
//   the quotient. In the following cycle it carries the remainder.
module div_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] m_in,
  input  logic [8*NREQ-1:0] q_in,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        quo,
  output logic [7:0]        rem,
  output logic              dz,
  output logic              arb_busy,
  output logic              div_start,
  output logic [7:0]        div_m,
  output logic [7:0]        div_q,
  input  logic              div_busy,
  input  logic [7:0]        div_out,
  output logic [2:0]        fsm_state
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    CAP_REM = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   cand;
  logic [7:0]    grant_m;
  logic [7:0]    grant_q;

`ifdef DIVARB_REMAINDER_EN
  logic [7:0]    quo_r;
  logic [7:0]    rem_reg;
  assign rem = rem_reg;
`else
  assign rem = 8'd0;
`endif

  assign fsm_state = state;

  // First set request at or after ptr, wrapping. cand is ptr+k reduced
  // modulo NREQ with one conditional subtract, since ptr+k < 2*NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!grant_found && req[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  assign grant_m = m_in[8*grant_idx +: 8];
  assign grant_q = q_in[8*grant_idx +: 8];

  // quo/rem/dz only change on entry to DONE, so outside the done cycle
  // they keep the previous result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      done      <= '0;
      quo       <= '0;
      dz        <= 1'b0;
      arb_busy  <= 1'b0;
      div_start <= 1'b0;
      div_m     <= '0;
      div_q     <= '0;
`ifdef DIVARB_REMAINDER_EN
      quo_r     <= '0;
      rem_reg   <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            g        <= grant_idx;
            arb_busy <= 1'b1;
            if (grant_m == 8'd0) begin
              // Divide by zero is answered locally; the divider never starts.
              done  <= NREQ'(1) << grant_idx;
              quo   <= 8'hFF;
              dz    <= 1'b1;
`ifdef DIVARB_REMAINDER_EN
              rem_reg <= grant_q;
`endif
              state <= DONE;
            end else begin
              div_start <= 1'b1;
              div_m     <= grant_m;
              div_q     <= grant_q;
              state     <= START;
            end
          end
        end
        START: state <= WAIT_HI;
        WAIT_HI: begin
          if (div_busy) begin
            div_start <= 1'b0;
            state     <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!div_busy) begin
`ifdef DIVARB_REMAINDER_EN
            quo_r <= div_out;
            state <= CAP_REM;
`else
            quo   <= div_out;
            dz    <= 1'b0;
            done  <= NREQ'(1) << g;
            state <= DONE;
`endif
          end
        end
`ifdef DIVARB_REMAINDER_EN
        CAP_REM: begin
          quo     <= quo_r;
          rem_reg <= div_out;
          dz      <= 1'b0;
          done    <= NREQ'(1) << g;
          state   <= DONE;
        end
`endif
        DONE: begin
          arb_busy <= 1'b0;
          ptr      <= (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//   Bench for div_arbiter with NREQ=4. A behavioural divider answers the
//   arbiter with a random accept delay and a random busy length. A
//   round-robin model predicts the order of results from the request set.
//   The driver pushes each predicted result into exp_q when the requests
//   are raised. The monitor pops from exp_q on every done pulse and compares.
//   Define DIVARB_REMAINDER_EN for both files to run the remainder build.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int EW = 19;  // {idx[1:0], quo[7:0], rem[7:0], dz}
`ifdef DIVARB_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] m_in;
  logic [8*N-1:0] q_in;
  logic [N-1:0]   done;
  logic [7:0]     quo;
  logic [7:0]     rem;
  logic           dz;
  logic           arb_busy;
  logic           div_start;
  logic [7:0]     div_m;
  logic [7:0]     div_q;
  logic           div_busy;
  logic [7:0]     div_out;
  logic [2:0]     fsm_state;

  div_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .m_in(m_in), .q_in(q_in),
    .done(done), .quo(quo), .rem(rem), .dz(dz), .arb_busy(arb_busy),
    .div_start(div_start), .div_m(div_m), .div_q(div_q),
    .div_busy(div_busy), .div_out(div_out), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural divider ----------------
  // Accepts start after acc_wait extra cycles, stays busy for h cycles.
  // Then it shows the quotient for one cycle, followed by the remainder.
  int         acc_wait, load_d, cnt;
  int         cur_d, cur_h, h_pick, d_pick;
  logic [7:0] dv_quo, dv_rem;
  logic       show_rem;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_busy <= 1'b0;
      div_out  <= 8'd0;
      acc_wait <= 0;
      load_d   <= 0;
      cnt      <= 0;
      cur_d    <= 0;
      cur_h    <= 0;
      show_rem <= 1'b0;
    end else if (!div_busy) begin
      if (show_rem) begin
        div_out  <= dv_rem;
        show_rem <= 1'b0;
      end
      if (div_start) begin
        if (acc_wait == 0) begin
          h_pick   = $urandom_range(1, 5);
          d_pick   = $urandom_range(0, 2);
          div_busy <= 1'b1;
          cnt      <= h_pick - 1;
          cur_h    <= h_pick;
          cur_d    <= load_d;
          acc_wait <= d_pick;
          load_d   <= d_pick;
          dv_quo   <= (div_m == 0) ? 8'hFF : div_q / div_m;
          dv_rem   <= (div_m == 0) ? div_q : div_q % div_m;
        end else begin
          acc_wait <= acc_wait - 1;
        end
      end
    end else begin
      if (cnt == 0) begin
        div_busy <= 1'b0;
        div_out  <= dv_quo;
        show_rem <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            model_ptr = 0;
  logic [7:0]    op_m[N];
  logic [7:0]    op_q[N];

  function automatic logic [EW-1:0] exp_entry(input int idx, input logic [7:0] m, input logic [7:0] q);
    logic [7:0] eq, er;
    logic       ez;
    if (m == 8'd0) begin
      eq = 8'hFF;
      er = REM_EN ? q : 8'd0;
      ez = 1'b1;
    end else begin
      eq = q / m;
      er = REM_EN ? q % m : 8'd0;
      ez = 1'b0;
    end
    return {2'(idx), eq, er, ez};
  endfunction

  // Round-robin rule: the next winner is the first requester in the set at or
  // after the pointer. The pointer then moves one past the winner. A winner
  // leaves the set unless it keeps requesting.
  task automatic predict(input logic [N-1:0] set, input bit hold, input int nops);
    logic [N-1:0] live;
    int p;
    live = set;
    p    = model_ptr;
    for (int n = 0; n < nops; n++) begin
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && live[(p + k) % N]) pick = (p + k) % N;
      end
      if (pick >= 0) begin
        exp_q.push_back(exp_entry(pick, op_m[pick], op_q[pick]));
        p = (pick + 1) % N;
        if (!hold) live[pick] = 1'b0;
      end
    end
    model_ptr = p;
  endtask

  // ---------------- monitor ----------------
  logic          busy_prev, done_prev, seen_start;
  int            lat_cnt;
  logic [EW-1:0] e;
  logic [N-1:0]  e_onehot;

  always @(negedge clk) begin
    if (!reset) begin
      busy_prev  = 1'b0;
      done_prev  = 1'b0;
      seen_start = 1'b0;
      lat_cnt    = 0;
    end else begin
      if (arb_busy && !busy_prev) begin
        lat_cnt    = 1;
        seen_start = div_start;
      end else if (arb_busy) begin
        lat_cnt++;
        if (div_start) seen_start = 1'b1;
      end
      busy_prev = arb_busy;
      if (done != '0) begin
        check("done_gap", 32'(done_prev), 32'd0);
        check("busy_at_done", 32'(arb_busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e        = exp_q.pop_front();
          e_onehot = N'(1) << e[18:17];
          check("done_onehot", 32'(done), 32'(e_onehot));
          check("quo", 32'(quo), 32'(e[16:9]));
          check("rem", 32'(rem), 32'(e[8:1]));
          check("dz", 32'(dz), 32'(e[0]));
          if (e[0]) begin
            check("dz_latency", lat_cnt, 1);
            check("dz_no_start", 32'(seen_start), 32'd0);
          end else begin
            // START, accept delay, busy cycles, quotient pickup,
            // optional remainder pickup, done cycle.
            check("latency", lat_cnt, (REM_EN ? 4 : 3) + cur_d + cur_h);
          end
        end
      end
      done_prev = (done != '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [7:0] m, input logic [7:0] q);
    op_m[i] = m;
    op_q[i] = q;
    m_in[8*i +: 8] = m;
    q_in[8*i +: 8] = q;
  endtask

  task automatic check_reset_values();
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_div_m", 32'(div_m), 32'd0);
    check("rst_div_q", 32'(div_q), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    exp_q.delete();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Raise the request set and run until nops results arrive. Each requester
  // drops its request after its own done, unless hold is set.
  task automatic run_phase(input logic [N-1:0] set, input bit hold, input int nops);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    predict(set, hold, nops);
    req = set;
    while (got < nops && cyc < 60 * nops) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        got++;
        if (!hold) req = req & ~done;
        if (got == nops) req = '0;
      end
    end
    if (got < nops) begin
      check("phase_timeout", got, nops);
      req = '0;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    req   = '0;
    m_in  = '0;
    q_in  = '0;
    for (int i = 0; i < N; i++) set_op(i, 8'd1, 8'd0);
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    @(negedge clk);

    // Single request: 14 / 4.
    set_op(0, 8'd4, 8'd14);
    run_phase(4'b0001, 1'b0, 1);

    // All four at once from pointer 0, then requester 0 alone again.
    do_reset();
    set_op(0, 8'd2, 8'd10);
    set_op(1, 8'd3, 8'd10);
    set_op(2, 8'd5, 8'd10);
    set_op(3, 8'd7, 8'd10);
    run_phase(4'b1111, 1'b0, 4);
    set_op(0, 8'd9, 8'd100);
    run_phase(4'b0001, 1'b0, 1);

    // Divide by zero.
    set_op(2, 8'd0, 8'h5A);
    run_phase(4'b0100, 1'b0, 1);

    // Fairness: 1 and 2 keep requesting for six operations.
    set_op(1, 8'd6, 8'd200);
    set_op(2, 8'd13, 8'd77);
    run_phase(4'b0110, 1'b1, 6);

    // Reset while waiting for the divider to finish.
    begin
      bit hit;
      hit = 1'b0;
      set_op(3, 8'd9, 8'd200);
      req = 4'b1000;
      for (int c = 0; c < 40 && !hit; c++) begin
        @(negedge clk);
        if (div_busy && !div_start && arb_busy) hit = 1'b1;
      end
      check("reach_wait_lo", 32'(hit), 32'd1);
      reset = 1'b0;
      req   = '0;
      exp_q.delete();
      model_ptr = 0;
      @(negedge clk);
      check_reset_values();
      @(negedge clk);
      reset = 1'b1;
    end
    // Pointer must be back at 0: requester 1 wins before 3.
    set_op(1, 8'd5, 8'd123);
    set_op(3, 8'd11, 8'd250);
    run_phase(4'b1010, 1'b0, 2);

    // Random request sets and operands.
    for (int t = 0; t < 10; t++) begin
      logic [N-1:0] s;
      s = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        logic [7:0] m;
        m = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        set_op(i, m, 8'($urandom_range(0, 255)));
      end
      run_phase(s, 1'b0, $countones(s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one `divnonrest` 8-bit non-restoring divider among `NREQ` requesters. It latches the winning requester's operands, drives the divider's `start`/`M`/`Q`, tracks `busy`, captures the quotient and remainder from `outbus`, and returns them with a one-cycle done strobe. It sits between the client blocks and the single divider instance, and is the only master of that divider.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held high with stable operands until that requester's `done` bit pulses.
- `m_in`  in  8*NREQ  divisor for requester i at `[8*i+7:8*i]`.
- `q_in`  in  8*NREQ  dividend for requester i, same packing.
- `done`  out  NREQ  one-hot, one-cycle pulse: result for requester i is valid.
- `quo`  out  8  quotient, valid while `done` is non-zero.
- `rem`  out  8  remainder, valid while `done` is non-zero.
- `dz`  out  1  divide-by-zero flag, valid while `done` is non-zero.
- `arb_busy`  out  1  high from grant until the done cycle, inclusive.
- `div_start`  out  1  to divider `start`.
- `div_m`, `div_q`  out  8  to divider `M`, `Q`, registered.
- `div_busy`  in  1  from divider `busy`.
- `div_out`  in  8  from divider `outbus`.

## Operation
- Divider contract: `start` is sampled while high. `busy` rises after the divider accepts. In the first cycle `busy` is observed low after having been high, `outbus` holds the quotient. In the following cycle it holds the remainder.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, CAP_REM, DONE.
- IDLE: if any `req` bit is set, grant the first set bit at or after the round-robin pointer `ptr`, wrapping modulo NREQ. Latch the grant index `g` and its operands.
  - If the latched divisor is 0: go to DONE with `quo`=8'hFF, `rem`=dividend, `dz`=1. The divider is not started.
  - Otherwise go to START.
- START: `div_start`=1, `div_m`/`div_q` = latched operands. Go to WAIT_HI.
- WAIT_HI: `div_start` stays 1 until `div_busy`=1 is seen, then go to WAIT_LO.
- WAIT_LO: when `div_busy`=0, latch `div_out` into the quotient register and go to CAP_REM.
- CAP_REM: latch `div_out` into the remainder register and go to DONE.
- DONE: `done[g]`=1 for exactly one cycle and `quo`/`rem`/`dz` are driven. Set `ptr`=(g+1) mod NREQ. Go to IDLE.
- Requests arriving while not in IDLE wait; there is no queueing beyond the `req` levels.
- A requester dropping `req` after grant does not abort the operation; its `done` still pulses.
- Operands are latched at grant; later changes to `m_in`/`q_in` are ignored.

## Timing
- Reset values: `done`=0, `quo`=0, `rem`=0, `dz`=0, `arb_busy`=0, `div_start`=0, `div_m`=0, `div_q`=0, `ptr`=0, state IDLE.
- Reset asserted mid-operation: returns to IDLE immediately with the reset values above. No `done` is issued.
- Grant happens in the cycle after `req` is first seen high in IDLE. START follows one cycle later.
- Latency from the IDLE grant edge to `done` = 3 + (cycles for `busy` to go high) + (cycles `busy` is high) + 1.
- Divide-by-zero: `done` occurs 1 cycle after the grant edge.
- Back-to-back: after DONE, IDLE may grant the next requester in the following cycle. There is a minimum of 1 idle cycle between `done` pulses.
- `quo`, `rem` and `dz` are valid only during the `done` cycle. Outside that cycle they hold their last values.

## Configuration
- `DIVARB_REMAINDER_EN` defined: full sequence above; `rem` holds the divider's remainder.
- Not defined: the CAP_REM state is removed. WAIT_LO goes directly to DONE, latency is 1 cycle shorter, and `rem` is tied to 0. The divide-by-zero case still returns `rem`=0 in this mode.

## Test plan
- Single request, `req`=4'b0001, M=4, Q=14, with a behavioural divider model -> `done`=4'b0001, `quo`=3, `rem`=2, `dz`=0.
- All four requesting simultaneously, operands (2,10),(3,10),(5,10),(7,10) -> `done` order is 0,1,2,3; results 5/0, 3/1, 2/0, 1/3. Then requester 0 re-requests with requester 3 idle -> granted next.
- Divide by zero, M=0, Q=8'h5A -> `done` 1 cycle after grant, `quo`=8'hFF, `rem`=8'h5A, `dz`=1, `div_start` never asserted.
- Fairness: requesters 1 and 2 held high continuously for 6 operations -> grants alternate 1,2,1,2,1,2.
- Reset pulse low during WAIT_LO -> all outputs 0 next edge, no `done`. A fresh request afterwards completes correctly.
- Build without `DIVARB_REMAINDER_EN`, M=4, Q=14 -> `quo`=3, `rem`=0, latency 1 cycle shorter than the first scenario.
